// File: rtl/cpu32_ctrl_pkg.sv
// cpu32_ctrl_pkg: run-controller states and shared constants
package cpu32_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRIME   = 3'd1,
    RUN     = 3'd2,
    STEP    = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5,
    TIMEOUT = 3'd6
  } run_state_t;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam int DEF_PC_W = 8;
endpackage

// File: rtl/run_sat_counter.sv
// run_sat_counter: clearable up-counter that sticks at LIMIT
module run_sat_counter #(
  parameter int W = 16,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != LIMIT) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/cpu32_run_ctrl.sv
// cpu32_run_ctrl: run/step/pause sequencer with halt capture and watchdog for cpu32.
// Define RUN_CTRL_STATS_EN to add per-class instruction counters.
module cpu32_run_ctrl
  import cpu32_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX_CYCLES = 16'd1000,
  parameter int PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step_mode,
  input  logic            step,
  input  logic            abort,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     code,
`ifdef RUN_CTRL_STATS_EN
  input  logic            write_en,
  input  logic            imm_en,
  input  logic            branch_en,
  output logic [15:0]     alu_count,
  output logic [15:0]     imm_count,
  output logic [15:0]     branch_count,
`endif
  output logic            cpu_power,
  output logic            cpu_clk_en,
  output logic            busy,
  output logic            done,
  output logic            halted,
  output logic            timed_out,
  output logic [PC_W-1:0] halted_pc,
  output logic [15:0]     cycle_count,
  output logic [2:0]      state
);
  run_state_t state_q, state_d;
  logic step_mode_q, step_mode_d, clk_en_q, clk_en_d, done_q, done_d;
  logic [PC_W-1:0] halted_pc_q, halted_pc_d;
  logic halt, exec, launch, last, cnt_inc;
  always_comb begin
    halt = code[15:12] == HALT_OP;
    exec = state_q == RUN || state_q == STEP;
    launch = (state_q == IDLE || state_q == DONE || state_q == TIMEOUT) && start && !abort;
    last = cycle_count == MAX_CYCLES - 16'd1;
    state_d = state_q;
    case (state_q)
      IDLE, DONE, TIMEOUT: state_d = start ? PRIME : state_q;
      PRIME:               state_d = step_mode_q ? PAUSE : RUN;
      RUN, STEP:           state_d = halt ? DONE : last ? TIMEOUT : state_q == STEP ? PAUSE : RUN;
      PAUSE:               state_d = halt ? DONE : start ? RUN : step ? STEP : PAUSE;
      default:             state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    step_mode_d = launch ? step_mode : step_mode_q;
    halted_pc_d = launch ? '0 : (state_d == DONE && state_q != DONE) ? pc : halted_pc_q;
    // the halt edge and an aborted edge never count as executed instructions
    cnt_inc = exec && !halt && !abort;
    clk_en_d = state_d == RUN || state_d == STEP;
    done_d = state_d != state_q && (state_d == DONE || state_d == TIMEOUT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      step_mode_q <= 1'b0;
      clk_en_q    <= 1'b0;
      done_q      <= 1'b0;
      halted_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      clk_en_q    <= clk_en_d;
      done_q      <= done_d;
      halted_pc_q <= halted_pc_d;
    end
  run_sat_counter #(.W(16), .LIMIT(MAX_CYCLES)) u_cycle (
    .clk(clk), .reset(reset), .clr(launch), .inc(cnt_inc), .count(cycle_count)
  );
`ifdef RUN_CTRL_STATS_EN
  run_sat_counter #(.W(16), .LIMIT(16'hFFFF)) u_alu (
    .clk(clk), .reset(reset), .clr(launch), .inc(cnt_inc && write_en), .count(alu_count)
  );
  run_sat_counter #(.W(16), .LIMIT(16'hFFFF)) u_imm (
    .clk(clk), .reset(reset), .clr(launch), .inc(cnt_inc && imm_en), .count(imm_count)
  );
  run_sat_counter #(.W(16), .LIMIT(16'hFFFF)) u_branch (
    .clk(clk), .reset(reset), .clr(launch), .inc(cnt_inc && branch_en), .count(branch_count)
  );
`endif
  assign cpu_power  = !(state_q == IDLE || state_q == PRIME);
  assign cpu_clk_en = clk_en_q;
  assign busy       = state_q == PRIME || state_q == RUN || state_q == STEP || state_q == PAUSE;
  assign done       = done_q;
  assign halted     = state_q == DONE;
  assign timed_out  = state_q == TIMEOUT;
  assign halted_pc  = halted_pc_q;
  assign state      = state_q;
endmodule

// File: tb/tb_cpu32_run_ctrl.sv
// tb_cpu32_run_ctrl: random programs on a toy cpu32/ROM, checked against a trace-based run model
module tb_cpu32_run_ctrl;
  localparam logic [15:0] MAXC = 16'd5;
  logic clk = 0, reset = 1, start = 0, step_mode = 0, step = 0, abort = 0;
  logic [7:0] pc = 0, halted_pc;
  logic [15:0] code, cycle_count;
  logic cpu_power, cpu_clk_en, busy, done, halted, timed_out;
  logic [2:0] state;
  logic [15:0] rom [256];
  int n_chk = 0, n_fail = 0;
  int n_en, e_cnt;
  bit e_to;
  logic [7:0] e_hpc;
  logic [7:0] tr [16];

  cpu32_run_ctrl #(.MAX_CYCLES(MAXC), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .pc(pc), .code(code), .cpu_power(cpu_power), .cpu_clk_en(cpu_clk_en),
    .busy(busy), .done(done), .halted(halted), .timed_out(timed_out),
    .halted_pc(halted_pc), .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;
  assign code = rom[pc];

  // toy core: opcode B jumps to code[7:0], F is a no-op stop, anything else falls through
  function automatic logic [7:0] nxt(logic [7:0] p);
    return rom[p][15:12] == 4'hF ? p : rom[p][15:12] == 4'hB ? rom[p][7:0] : p + 8'd1;
  endfunction
  always @(posedge clk)
    if (!cpu_power) pc <= 8'd0;
    else if (cpu_clk_en) pc <= nxt(pc);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // walk the program from pc 0: first stop within MAXC instructions wins, else watchdog
  task automatic predict();
    logic [7:0] p = 8'd0;
    e_to = 1; n_en = MAXC; e_cnt = MAXC; e_hpc = 8'd0;
    for (int i = 0; i < MAXC && e_to; i++) begin
      tr[i] = p;
      if (rom[p][15:12] == 4'hF) begin
        e_to = 0; n_en = i + 1; e_cnt = i; e_hpc = p;
      end
      p = nxt(p);
    end
  endtask

  task automatic wait_done();
    int t = 0, en = 0;
    do begin
      tick();
      start = 0;
      t++;
      en += cpu_clk_en;
    end while (!done && t < 100);
    chk("run_latency", t, n_en + 1);
    chk("run_en_cycles", en, n_en);
  endtask

  task automatic final_chk();
    chk("end_done", done, 1);
    chk("end_state", state, e_to ? 6 : 5);
    chk("end_halted", halted, !e_to);
    chk("end_timed_out", timed_out, e_to);
    chk("end_halted_pc", halted_pc, e_hpc);
    chk("end_count", cycle_count, e_cnt);
    chk("end_power", cpu_power, 1);
    chk("end_clk_en", cpu_clk_en, 0);
    chk("end_busy", busy, 0);
    tick();
    chk("end_done_once", done, 0);
    chk("end_state_held", state, e_to ? 6 : 5);
  endtask

  task automatic do_run(bit sm, int resume);
    int steps, r;
    predict();
    start = 1; step_mode = sm;
    tick();
    start = 0; step_mode = 1'($urandom);
    chk("prime_state", state, 1);
    chk("prime_power", cpu_power, 0);
    chk("prime_clk_en", cpu_clk_en, 0);
    chk("prime_busy", busy, 1);
    chk("prime_count", cycle_count, 0);
    chk("prime_hpc", halted_pc, 0);
    if (!sm) begin
      wait_done();
      final_chk();
      return;
    end
    tick();
    chk("pause_state", state, 4);
    chk("pause_pc0", pc, 0);
    chk("pause_clk_en", cpu_clk_en, 0);
    chk("pause_power", cpu_power, 1);
    steps = e_to ? n_en : n_en - 1;
    r = (resume >= 0 && resume < steps) ? resume : steps;
    for (int i = 0; i < r; i++) begin
      step = 1;
      tick();
      step = 0;
      chk("step_state", state, 3);
      chk("step_clk_en", cpu_clk_en, 1);
      chk("step_pc", pc, tr[i]);
      tick();
      if (!(e_to && i == n_en - 1)) begin
        chk("step_back_pause", state, 4);
        chk("step_next_pc", pc, tr[i + 1]);
      end
    end
    if (r < steps) begin
      start = 1;
      n_en -= r;
      wait_done();
    end else if (!e_to) tick();
    final_chk();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    clear_rom();
    tick();
    chk("rst_state", state, 0);
    chk("rst_power", cpu_power, 0);
    chk("rst_clk_en", cpu_clk_en, 0);
    chk("rst_count", cycle_count, 0);
    reset = 0;
    tick();
    rom[0] = 16'h1005; rom[1] = 16'h2001; rom[2] = 16'hF000;
    do_run(0, -1);
    chk("t1_hpc", halted_pc, 2);
    chk("t1_count", cycle_count, 2);
    do_run(1, -1);
    chk("t4_count", cycle_count, 2);
    chk("t4_halted", halted, 1);
    clear_rom();
    rom[0] = 16'hF000;
    do_run(0, -1);
    chk("t2_hpc", halted_pc, 0);
    chk("t2_count", cycle_count, 0);
    clear_rom();
    rom[4] = 16'hF000;
    do_run(1, 1);
    chk("resume_hpc", halted_pc, 4);
    clear_rom();
    rom[1] = 16'hB000;
    do_run(0, -1);
    chk("t3_timed_out", timed_out, 1);
    chk("t3_count", cycle_count, 5);
    do_run(1, -1);
    // abort while running the loop
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("abort_pre_count", cycle_count, 3);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_state", state, 0);
    chk("abort_power", cpu_power, 0);
    chk("abort_clk_en", cpu_clk_en, 0);
    chk("abort_done", done, 0);
    chk("abort_count_held", cycle_count, 3);
    tick();
    chk("abort_no_done", done, 0);
    start = 1;
    tick();
    start = 0;
    chk("restart_prime", state, 1);
    chk("restart_count", cycle_count, 0);
    abort = 1;
    tick();
    abort = 0;
    // asynchronous reset between edges while running
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    #3 reset = 1;
    #1;
    chk("areset_state", state, 0);
    chk("areset_power", cpu_power, 0);
    chk("areset_clk_en", cpu_clk_en, 0);
    chk("areset_busy", busy, 0);
    chk("areset_count", cycle_count, 0);
    chk("areset_flags", {done, halted, timed_out}, 0);
    start = 1; step = 1;
    tick();
    tick();
    chk("reset_ignores_start", state, 0);
    start = 0; step = 0;
    reset = 0;
    tick();
    chk("post_reset_state", state, 0);
    repeat (40) begin
      clear_rom();
      for (int i = 0; i < 16; i++) begin
        int r = $urandom_range(0, 9);
        rom[i] = r == 0 ? {4'hF, 12'($urandom)} :
                 r == 1 ? {8'hB0, 8'($urandom_range(0, 15))} :
                 {4'($urandom_range(0, 10)), 12'($urandom)};
      end
      do_run(1'($urandom), $urandom_range(0, 1) == 0 ? -1 : int'($urandom_range(0, 4)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu32_run_ctrl.md
Name: cpu32_run_ctrl

Overview:
Run/step sequencer for the cpu32 core and its program_rom.
- Drives the core's power input and a clock-enable (consumed by the clock-gating cell) so software or a debug host can start, single-step, pause, resume and abort program execution.
- Watches the fetched instruction for the stop opcode (code[15:12]==4'hF) and captures the halt PC.
- Counts executed instructions and enforces a watchdog cycle limit.

Parameters:
MAX_CYCLES, 16'd1000, watchdog limit; reaching it without a halt ends the run in TIMEOUT.
PC_W, 8, program-counter width (matches cpu32/program_rom).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  pulse: begin a run (IDLE/DONE/TIMEOUT) or resume free-run (PAUSE).
step_mode  input  1  sampled with start from IDLE/DONE/TIMEOUT: 1 = enter PAUSE after priming instead of RUN.
step  input  1  pulse: execute exactly one instruction while in PAUSE.
abort  input  1  pulse: return to IDLE from any state.
pc  input  PC_W  cpu32 current PC.
code  input  16  instruction from program_rom at pc.
cpu_power  output  1  cpu32 power (0 holds core in reset).
cpu_clk_en  output  1  core clock enable.
busy  output  1  high in PRIME, RUN, STEP, PAUSE.
done  output  1  one-cycle pulse on entry to DONE or TIMEOUT.
halted  output  1  high while in DONE.
timed_out  output  1  high while in TIMEOUT.
halted_pc  output  PC_W  PC at which the stop opcode was seen.
cycle_count  output  16  instructions executed this run (stop opcode excluded).
state  output  3  encoded FSM state for debug.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including cpu_power, cpu_clk_en, halted_pc, cycle_count.
- States: IDLE, PRIME, RUN, STEP, PAUSE, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start → PRIME.
  - step_mode is latched on this transition.
  - cycle_count and halted_pc are cleared.
- PRIME: exactly one cycle; cpu_power=0, cpu_clk_en=0 (core reset to pc=0). Next state is PAUSE if the latched step_mode=1, else RUN.
- RUN: cpu_power=1, cpu_clk_en=1. Each posedge:
  - If code[15:12]==4'hF → DONE; halted_pc<=pc; cycle_count unchanged.
  - Else if cycle_count==MAX_CYCLES-1 → count increments to MAX_CYCLES, then TIMEOUT.
  - Else cycle_count+1.
- PAUSE: cpu_power=1, cpu_clk_en=0; pc/code are stable.
  - If code[15:12]==4'hF → DONE immediately (halted_pc<=pc).
  - Else step → STEP; start → RUN.
  - step and start both high: start wins.
- STEP: one enabled cycle, with the same halt/timeout/count rules as RUN, then returns to PAUSE.
- DONE: cpu_power=1, cpu_clk_en=0, halted=1. TIMEOUT: cpu_power=1, cpu_clk_en=0, timed_out=1.
- cpu_clk_en is a registered decode of the next state, so it is high exactly during RUN/STEP cycles. The halt instruction's edge is enabled but causes no side effects (stop is a no-op in cpu32).
- abort has priority over all other inputs in every state.
  - Next cycle: IDLE, cpu_power=0, cpu_clk_en=0.
  - cycle_count and halted_pc are held, not cleared.
  - No done pulse is generated.
- start while busy (other than resume from PAUSE) is ignored. step outside PAUSE is ignored.
- cycle_count saturates at MAX_CYCLES and never wraps.
- Halt check takes priority over timeout on the same edge.
- Reset asserted mid-run: immediate IDLE and core powered down.

Optional Feature:
RUN_CTRL_STATS_EN
- Defined: adds inputs write_en, imm_en, branch_en (1 bit each, from cpu32) and outputs alu_count, imm_count, branch_count (16 bits each).
  - Each counter increments on an enabled non-halt cycle where its input is high.
  - Counters clear with cycle_count in PRIME and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package cpu32_ctrl_pkg:
  - state enum with 3-bit encodings (IDLE=0, PRIME=1, RUN=2, STEP=3, PAUSE=4, DONE=5, TIMEOUT=6);
  - HALT_OP=4'hF;
  - PC_W default.
- One sub-module, run_sat_counter: clear, increment enable, saturation limit parameter. Used for cycle_count and, under the macro, for the stats counters.

Test Plan:
1. ROM: pc0 loadi, pc1 add, pc2 4'hF stop; start with step_mode=0.
   - PRIME is 1 cycle with cpu_power=0.
   - done pulses 3 cycles after PRIME exits; halted_pc=2, cycle_count=2, halted=1.
2. Stop opcode at pc0.
   - RUN for 1 cycle, then DONE; halted_pc=0, cycle_count=0.
3. MAX_CYCLES=5, ROM loops with a branch to pc0.
   - TIMEOUT after 5 enabled cycles; cycle_count=5, timed_out=1, done pulses once.
4. Same program as test 1 with step_mode=1.
   - Enters PAUSE with pc=0.
   - Each step advances pc by exactly 1 with cpu_clk_en high for one cycle.
   - After 2 steps (pc=2), DONE is reached without a third step; cycle_count=2.
5. abort mid-RUN at cycle 3 of the looping program.
   - Next cycle: IDLE, cpu_power=0, no done pulse, cycle_count=3 held.
   - A following start clears cycle_count to 0 in PRIME.
6. reset asserted asynchronously between clock edges during RUN.
   - All outputs go to 0 immediately, state=IDLE.
   - start and step pulses during reset are ignored.
